// File: rtl/mstr_addr_chan_arbiter.sv
// Round-robin arbiter sharing one crossbar address channel; winner latched into an output register.
// Optional ARB_QOS_EN: highest req_qos wins, ties broken round-robin. Accept->out_valid 1 cycle; out held until out_ready.
module mstr_addr_chan_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int PAYLOAD_WIDTH   = 64,
  parameter int MAX_OUTSTANDING = 8,
  localparam int MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                 XBAR_CLK,
  input  logic                                 sysReset,
  input  logic [NUM_MASTERS-1:0]               req_valid,
  input  logic [NUM_MASTERS*PAYLOAD_WIDTH-1:0] req_payload,
  input  logic [NUM_MASTERS*4-1:0]             req_qos,
  output logic [NUM_MASTERS-1:0]               req_ready,
  output logic                                 out_valid,
  output logic [PAYLOAD_WIDTH-1:0]             out_payload,
  output logic [MIDX_W-1:0]                    out_mstr_idx,
  input  logic                                 out_ready,
  input  logic                                 txn_done,
  output logic [CNT_W-1:0]                     outstanding,
  output logic                                 err_underflow
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                   state_q;
  logic [MIDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                     out_valid_q;
  logic [PAYLOAD_WIDTH-1:0] out_payload_q;
  logic [MIDX_W-1:0]        out_mstr_idx_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     err_q, err_d;

  logic [PAYLOAD_WIDTH-1:0] pay_a [NUM_MASTERS];
  logic [3:0]               qos_a [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign pay_a[g] = req_payload[g*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    assign qos_a[g] = req_qos[g*4 +: 4];
  end

  logic [MIDX_W-1:0] win_idx;
  logic              any_vld;
  logic [3:0]        best_qos;
  logic [MIDX_W:0]   scan_sum;
  logic [MIDX_W-1:0] scan_idx;

  // Scan masters in round-robin order starting at rr_ptr; the first (or highest-QOS) valid wins.
  always_comb begin
    win_idx  = '0;
    any_vld  = 1'b0;
    best_qos = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (MIDX_W+1)'(k);
      if (scan_sum >= (MIDX_W+1)'(NUM_MASTERS)) scan_sum = scan_sum - (MIDX_W+1)'(NUM_MASTERS);
      scan_idx = scan_sum[MIDX_W-1:0];
`ifdef ARB_QOS_EN
      if (req_valid[scan_idx] && (!any_vld || qos_a[scan_idx] > best_qos)) begin
        any_vld  = 1'b1;
        win_idx  = scan_idx;
        best_qos = qos_a[scan_idx];
      end
`else
      if (req_valid[scan_idx] && !any_vld) begin
        any_vld = 1'b1;
        win_idx = scan_idx;
      end
`endif
    end
  end

`ifndef ARB_QOS_EN
  logic unused_qos;
  assign unused_qos = ^{req_qos, best_qos, qos_a[0]};
`endif

  logic grant, hs;
  assign grant = (state_q == IDLE) && any_vld && !sysReset &&
                 (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign req_ready = grant ? (NUM_MASTERS'(1) << win_idx) : '0;
  assign hs = out_valid_q & out_ready;

  always_comb begin
    rr_ptr_d = out_mstr_idx_q + MIDX_W'(1);
    if ({1'b0, out_mstr_idx_q} + (MIDX_W+1)'(1) >= (MIDX_W+1)'(NUM_MASTERS)) rr_ptr_d = '0;
  end

  // Handshake and retire in the same cycle cancel out; retire at zero only flags the error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (hs && !txn_done) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!hs && txn_done) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge XBAR_CLK) begin
    if (sysReset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      out_valid_q    <= 1'b0;
      out_payload_q  <= '0;
      out_mstr_idx_q <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      case (state_q)
        IDLE: if (grant) begin
          state_q        <= SEND;
          out_valid_q    <= 1'b1;
          out_payload_q  <= pay_a[win_idx];
          out_mstr_idx_q <= win_idx;
        end
        SEND: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          rr_ptr_q    <= rr_ptr_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_payload   = out_payload_q;
  assign out_mstr_idx  = out_mstr_idx_q;
  assign outstanding   = cnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_mstr_addr_chan_arbiter.sv
// Bench for mstr_addr_chan_arbiter: transaction-level model compared every cycle, directed scenarios plus random traffic.
module tb_mstr_addr_chan_arbiter;
  localparam int N = 4, PW = 64, MAX = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_payload;
  logic [N*4-1:0]  req_qos;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [PW-1:0]   out_payload;
  logic [1:0]      out_mstr_idx;
  logic            out_ready;
  logic            txn_done;
  logic [3:0]      outstanding;
  logic            err_underflow;

  logic [PW-1:0] pay [N];
  logic [3:0]    qos [N];

  always_comb begin
    req_payload = '0;
    req_qos     = '0;
    for (int i = 0; i < N; i++) begin
      req_payload[i*PW +: PW] = pay[i];
      req_qos[i*4 +: 4]       = qos[i];
    end
  end

  mstr_addr_chan_arbiter #(.NUM_MASTERS(N), .PAYLOAD_WIDTH(PW), .MAX_OUTSTANDING(MAX)) dut (
    .XBAR_CLK(clk), .sysReset(rst), .req_valid(req_valid), .req_payload(req_payload),
    .req_qos(req_qos), .req_ready(req_ready), .out_valid(out_valid), .out_payload(out_payload),
    .out_mstr_idx(out_mstr_idx), .out_ready(out_ready), .txn_done(txn_done),
    .outstanding(outstanding), .err_underflow(err_underflow));

  always #5 clk = ~clk;

  // Model: one held transaction (or none), a pointer, a counter, a sticky flag.
  bit            m_pend = 0;
  logic [PW-1:0] m_pay = '0;
  int            m_idx = 0, m_rr = 0, m_cnt = 0, m_win = -1;
  bit            m_err = 0;
  logic [N-1:0]  exp_rdy = '0;
  int            checks = 0, errors = 0;

  function automatic int model_winner();
    int w = -1;
    int bq = -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_rr + k) % N;
      if (req_valid[i]) begin
`ifdef ARB_QOS_EN
        if (int'(qos[i]) > bq) begin bq = int'(qos[i]); w = i; end
`else
        if (w < 0) w = i;
`endif
      end
    end
    return w;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    #1;
    m_win = model_winner();
    if (!rst && !m_pend && m_cnt < MAX && m_win >= 0) exp_rdy = N'(1) << m_win;
    else exp_rdy = '0;
    chk("req_ready",     64'(req_ready),     64'(exp_rdy));
    chk("out_valid",     64'(out_valid),     64'(m_pend));
    chk("out_payload",   out_payload,        m_pay);
    chk("out_mstr_idx",  64'(out_mstr_idx),  64'(m_idx));
    chk("outstanding",   64'(outstanding),   64'(m_cnt));
    chk("err_underflow", 64'(err_underflow), 64'(m_err));
  endtask

  task automatic tick();
    bit hs;
    @(posedge clk);
    if (rst) begin
      m_pend = 0; m_pay = '0; m_idx = 0; m_rr = 0; m_cnt = 0; m_err = 0;
    end else begin
      hs = m_pend && out_ready;
      if (!m_pend && exp_rdy != '0) begin
        m_pend = 1; m_idx = m_win; m_pay = pay[m_win];
      end else if (hs) begin
        m_pend = 0; m_rr = (m_idx + 1) % N;
      end
      if (hs && !txn_done) m_cnt++;
      else if (!hs && txn_done) begin
        if (m_cnt == 0) m_err = 1;
        else m_cnt--;
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (exp_rdy[i]) pay[i] = {$urandom, $urandom};
  endtask

  task automatic step();
    cyc();
    tick();
  endtask

  initial begin
    int g;
    int order [5] = '{0, 1, 2, 3, 0};
    rst = 1; req_valid = '0; out_ready = 0; txn_done = 0;
    for (int i = 0; i < N; i++) begin pay[i] = {$urandom, $urandom}; qos[i] = 4'($urandom); end
    @(negedge clk);
    repeat (3) step();
    rst = 0;
    cyc();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_payload", out_payload, 0);
    chk("rst_err", 64'(err_underflow), 0);
    tick();

    // All masters valid, retire on every handshake: strict rotation, grant every other cycle.
    req_valid = 4'b1111; out_ready = 1; g = 0;
    for (int c = 0; c < 10; c++) begin
      txn_done = m_pend;
      cyc();
      chk("t1_out_valid", 64'(out_valid), 64'(c % 2));
      if (req_ready != '0) begin
        if (g < 5) chk("t1_order", 64'(onehot_idx(req_ready)), 64'(order[g]));
        g++;
      end
      tick();
    end
    chk("t1_grants", 64'(g), 5);

    req_valid = 4'b0100; pay[2] = 64'hA5; out_ready = 0; txn_done = 0;
    cyc();
    chk("t2_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0; out_ready = 1; txn_done = 1;
    cyc();
    chk("t2_out_valid", 64'(out_valid), 1);
    chk("t2_payload", out_payload, 64'hA5);
    chk("t2_idx", 64'(out_mstr_idx), 2);
    tick();

    req_valid = 4'b0010; pay[1] = 64'h1234_5678_9ABC_DEF0; out_ready = 0; txn_done = 0;
    step();
    req_valid = 4'b1111;
    repeat (5) begin
      cyc();
      chk("t3_hold", out_payload, 64'h1234_5678_9ABC_DEF0);
      chk("t3_ready", 64'(req_ready), 0);
      tick();
    end
    out_ready = 1; txn_done = 1;
    cyc();
    chk("t3_complete", 64'(out_valid), 1);
    tick();
    txn_done = 0;
    cyc();
    chk("t3_drop", 64'(out_valid), 0);
    tick();
    req_valid = '0; txn_done = 1;
    step();
    txn_done = 0;
    step();

    // Fill to the limit with no retirements.
    req_valid = 4'b1111; out_ready = 1; txn_done = 0; g = 0;
    repeat (24) begin
      cyc();
      if (req_ready != '0) g++;
      tick();
    end
    chk("t4_grants", 64'(g), 8);
    chk("t4_full", 64'(outstanding), 8);
    txn_done = 1;
    cyc();
    chk("t4_blocked", 64'(req_ready), 0);
    tick();
    txn_done = 0;
    cyc();
    chk("t4_after_done", 64'(outstanding), 7);
    chk("t4_ninth", 64'(req_ready != '0), 1);
    tick();
    step();

    req_valid = '0; txn_done = 1;
    repeat (5) step();
    txn_done = 0;
    cyc();
    chk("t5_three", 64'(outstanding), 3);
    tick();
    req_valid = 4'b0001; out_ready = 0;
    step();
    req_valid = '0; out_ready = 1; txn_done = 1;
    cyc();
    chk("t5_hs", 64'(out_valid), 1);
    tick();
    txn_done = 0;
    cyc();
    chk("t5_same", 64'(outstanding), 3);
    tick();
    txn_done = 1;
    repeat (4) step();
    txn_done = 0;
    cyc();
    chk("t5_err", 64'(err_underflow), 1);
    chk("t5_zero", 64'(outstanding), 0);
    tick();

    // Reset while a request is held in SEND.
    req_valid = 4'b0100; out_ready = 0;
    step();
    req_valid = '0; out_ready = 1;
    step();
    req_valid = 4'b0100; out_ready = 0;
    step();
    req_valid = '0; rst = 1;
    step();
    rst = 0; req_valid = 4'b1111;
    cyc();
    chk("t6_out_valid", 64'(out_valid), 0);
    chk("t6_outstanding", 64'(outstanding), 0);
    chk("t6_err", 64'(err_underflow), 0);
    chk("t6_rr_ptr", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0; out_ready = 1;
    step();
    step();

`ifdef ARB_QOS_EN
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    qos[0] = 4'd1; qos[1] = 4'd9; qos[2] = 4'd9; qos[3] = 4'd3;
    req_valid = 4'b1111;
    cyc();
    chk("qos_first", 64'(req_ready), 64'b0100);
    tick();
    step();
    cyc();
    chk("qos_second", 64'(req_ready), 64'b0010);
    tick();
    step();
`endif

    // Random traffic: masters hold payload until accepted, occasionally withdraw; sporadic resets.
    repeat (3000) begin
      rst       = ($urandom_range(99) == 0);
      out_ready = ($urandom_range(9) < 7);
      txn_done  = ($urandom_range(9) < 3);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          req_valid[i] = 1'($urandom);
          pay[i] = {$urandom, $urandom};
          qos[i] = 4'($urandom);
        end else if ($urandom_range(19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
